addsub_digit_serial: RTL
========================

Name: addsub_digit_serial

Overview:
- Parametrised, multi-cycle add/subtract unit. It is the sequential successor of the fixed 4-bit add-with-carry / subtract-with-carry-out blocks.
- Processes WIDTH-bit operands DIGIT bits per cycle through a registered carry chain, trading latency for a narrow adder.
- Valid/ready handshake on input and output, so it drops into streaming datapaths and multi-word arithmetic chains (CIN/COUT).

Parameters:
- WIDTH, 16, operand and result width in bits.
- DIGIT, 4, bits processed per cycle. WIDTH must be an integer multiple of DIGIT; N = WIDTH/DIGIT cycles per operation. DIGIT == WIDTH is legal (N = 1).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- ASYNCRESETN  in  1  reset, asynchronous, active-low.
- I_VALID  in  1  operands and mode presented.
- I_READY  out  1  block can accept an operation.
- I0  in  WIDTH  first operand.
- I1  in  WIDTH  second operand.
- SUB  in  1  0 = add, 1 = subtract.
- CIN  in  1  carry-in (in subtract mode, 1 = no borrow-in).
- O_VALID  out  1  result available.
- O_READY  in  1  consumer accepts result.
- O  out  WIDTH  result.
- COUT  out  1  carry-out of the MSB (in subtract mode, 1 = no borrow).
- V  out  1  two's-complement signed overflow.

Behaviour:
- Arithmetic:
  - ADD: {COUT,O} = I0 + I1 + CIN.
  - SUB: {COUT,O} = I0 + ~I1 + CIN.
  - All operands are unsigned WIDTH bits; the sum is WIDTH+1 bits.
  - V = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- FSM has three states: IDLE, RUN, DONE.
  - IDLE: I_READY = 1. On an edge where I_VALID && I_READY, latch I0, I1 (inverted if SUB), CIN and SUB; clear the digit counter; go to RUN. Inputs are ignored otherwise.
  - RUN: I_READY = 0. Each edge adds the next DIGIT-bit slice, LSB slice first, plus the carry register. It stores the slice result, updates the carry, and increments the counter. On the edge processing slice N-1, capture COUT and V, drive O, and go to DONE.
  - DONE: O_VALID = 1; O, COUT and V are held stable. On an edge where O_VALID && O_READY, go to IDLE.
- Latency and throughput:
  - Accept edge k → O_VALID high after edge k+N.
  - Minimum issue interval is N+2 cycles; there is no accept in the same cycle as the output transfer.
- Backpressure: O_READY may stay low indefinitely. Outputs hold and I_READY stays 0; I_VALID in RUN or DONE has no effect.
- The operand registers are internal. Changes to I0, I1, SUB or CIN after the accept edge do not affect the result.
- O_VALID asserts only in DONE and deasserts on the transfer edge. The result of an accepted operation is never dropped or duplicated.
- Reset (ASYNCRESETN low, at any time including mid-RUN):
  - Immediately: state = IDLE, O = 0, COUT = 0, V = 0, O_VALID = 0, carry and counter = 0. The in-flight operation is discarded.
  - I_READY is 0 while reset is asserted and 1 from the first cycle after deassertion.
- Counter width is clog2(N), minimum 1 bit. No counter wrap is observable, because the FSM leaves RUN at N-1.

Test Plan:
All scenarios use WIDTH=16, DIGIT=4 (N=4).
1. ADD I0=0x1234, I1=0x0FCD, CIN=0, accept at edge k → O_VALID rises after edge k+4; O=0x2201, COUT=0, V=0.
2. SUB I0=0x0005, I1=0x0007, CIN=1 → O=0xFFFE, COUT=0 (borrow), V=0. Then SUB I0=0x8000, I1=0x0001, CIN=1 → O=0x7FFF, COUT=1, V=1.
3. ADD I0=0xFFFF, I1=0x0001, CIN=0 → O=0x0000, COUT=1, V=0. Then ADD 0x7FFF+0x0000 with CIN=1 → O=0x8000, COUT=0, V=1.
4. Backpressure: hold O_READY=0 for 5 cycles after O_VALID → O, COUT and V stable; I_READY=0; a second I_VALID pulse is ignored. After the transfer edge: O_VALID=0, I_READY=1 next cycle, and the next op completes with the correct result.
5. Operand change mid-RUN: change I0/I1/SUB every cycle after accept of ADD 0x00FF+0x0001 → O=0x0100 regardless.
6. Reset: assert ASYNCRESETN=0 between clock edges after 2 slices of a SUB → O_VALID=0 and O=0 immediately; after release I_READY=1 and ADD 0x0003+0x0004 yields 0x0007. Also rerun scenario 1 with DIGIT=16 → O_VALID after edge k+1, same O.

Source files
------------

// File: rtl/addsub_digit_serial.sv
// Digit-serial add/subtract unit.
// Handles WIDTH-bit operands DIGIT bits per cycle, LSB slice first, through a
// registered carry. Subtraction is done as I0 + ~I1 + CIN, so CIN = 1 means
// "no borrow-in" and COUT = 1 means "no borrow".
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a new operation (I_READY = 1 once out of reset)
// RUN   | one DIGIT-bit slice per cycle, counter selects the slice
// DONE  | result held on O/COUT/V with O_VALID = 1 until O_READY

module addsub_digit_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic             I_VALID,
    output logic             I_READY,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic             SUB,
    input  logic             CIN,
    output logic             O_VALID,
    input  logic             O_READY,
    output logic [WIDTH-1:0] O,
    output logic             COUT,
    output logic             V
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;

    logic [31:0]      base;
    logic [DIGIT-1:0] a_sl;
    logic [DIGIT-1:0] b_sl;
    logic [DIGIT:0]   sl_sum;
    logic [WIDTH-1:0] res_next;
    logic             last_slice;
    logic             msb_cin;

    // Slice adder: select the current slice, add it with the carry register
    // and merge the slice result into the partial result word.
    always_comb begin
        base       = 32'(cnt_q) * DIGIT;
        a_sl       = a_q[base +: DIGIT];
        b_sl       = b_q[base +: DIGIT];
        sl_sum     = {1'b0, a_sl} + {1'b0, b_sl} + {{DIGIT{1'b0}}, carry_q};
        res_next   = res_q;
        res_next[base +: DIGIT] = sl_sum[DIGIT-1:0];
        last_slice = (cnt_q == CW'(N - 1));
        // Carry into the MSB recovered from the MSB sum bit, valid for any DIGIT.
        msb_cin    = a_sl[DIGIT-1] ^ b_sl[DIGIT-1] ^ sl_sum[DIGIT-1];
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state   <= IDLE;
            I_READY <= 1'b0;
            O_VALID <= 1'b0;
            O       <= '0;
            COUT    <= 1'b0;
            V       <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!I_READY) begin
                        // first cycle after reset release
                        I_READY <= 1'b1;
                    end else if (I_VALID) begin
                        a_q     <= I0;
                        b_q     <= SUB ? ~I1 : I1;
                        carry_q <= CIN;
                        cnt_q   <= '0;
                        I_READY <= 1'b0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    res_q   <= res_next;
                    carry_q <= sl_sum[DIGIT];
                    if (last_slice) begin
                        O       <= res_next;
                        COUT    <= sl_sum[DIGIT];
                        V       <= msb_cin ^ sl_sum[DIGIT];
                        O_VALID <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    if (O_READY) begin
                        O_VALID <= 1'b0;
                        I_READY <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
